// File: rtl/ack_bus_pkg.sv
// rtl/ack_bus_pkg.sv - shared ack-bus IDs, requester FSM encoding and sizing constants
package ack_bus_pkg;

    localparam logic [1:0] ID_MEM  = 2'b00;
    localparam logic [1:0] ID_SHA  = 2'b01;
    localparam logic [1:0] ID_AES  = 2'b10;
    localparam logic [1:0] ID_CTRL = 2'b11;

    localparam int DEFAULT_PEND_W = 4;
    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_GAP  = 2'b10
    } req_state_e;

endpackage

// File: rtl/ack_pending_counter.sv
// rtl/ack_pending_counter.sv - saturating pending-ack up/down counter with drop detect
module ack_pending_counter
    import ack_bus_pkg::*;
#(
    parameter int PEND_W = DEFAULT_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic [PEND_W-1:0] cnt_next,
    output logic              drop
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    // A push and a pop in the same cycle cancel, so a full counter only drops an unmatched push.
    always_comb begin
        cnt_d = cnt_q;
        drop  = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == CNT_MAX) begin
                drop = 1'b1;
            end else begin
                cnt_d = cnt_q + PEND_W'(1);
            end
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/ack_bus_requester.sv
// rtl/ack_bus_requester.sv - ack-bus endpoint requester FSM; ACK_REQ_TIMEOUT_EN adds request timeout
module ack_bus_requester
    import ack_bus_pkg::*;
#(
    parameter logic [1:0] SOURCE_ID = ID_MEM,
    parameter int         PEND_W    = DEFAULT_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ack_push,
    output logic              req,
    input  logic              ack_ready,
    input  logic [1:0]        winner_source_id,
    input  logic              ack_event,
    output logic [PEND_W-1:0] pending_cnt,
    output logic              busy,
    output logic              overflow,
    output logic              grant_err,
    output logic              timeout
);

    req_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              grant_err_q, grant_err_d;
    logic              valid_grant;
    logic              expire;
    logic              cnt_dec;
    logic              cnt_drop;
    logic [PEND_W-1:0] cnt_next;

    assign valid_grant = (state_q == ST_REQ) && ack_ready && ack_event
                         && (winner_source_id == SOURCE_ID);
    assign cnt_dec     = valid_grant || expire;

    ack_pending_counter #(
        .PEND_W (PEND_W)
    ) u_pending_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (ack_push),
        .dec      (cnt_dec),
        .cnt      (pending_cnt),
        .cnt_next (cnt_next),
        .drop     (cnt_drop)
    );

`ifdef ACK_REQ_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;

    // wait_q holds the number of REQ cycles already spent; this cycle is the last one allowed at 254.
    assign expire = (state_q == ST_REQ) && !valid_grant
                    && (wait_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d    = (state_q == ST_REQ) ? wait_q + 8'd1 : 8'd0;
        timeout_d = timeout_q || expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Both IDLE and GAP look at the post-update count so a push is seen on the very next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cnt_next != '0) state_d = ST_REQ;
            ST_REQ:  if (cnt_dec) state_d = ST_GAP;
            ST_GAP:  state_d = (cnt_next != '0) ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        req_d       = (state_d == ST_REQ);
        busy_d      = (state_d != ST_IDLE) || (cnt_next != '0);
        overflow_d  = overflow_q || cnt_drop;
        grant_err_d = grant_err_q || (ack_ready && !valid_grant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign req       = req_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_ack_bus_requester.sv
// tb/tb_ack_bus_requester.sv - self-checking bench for ack_bus_requester (vectors, corner sequences, random vs model)
module tb_ack_bus_requester;

    localparam logic [1:0] SRC  = 2'b01;
    localparam int         PW   = 4;
    localparam int         CMAX = (1 << PW) - 1;
`ifdef ACK_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, ack_push, ack_ready, ack_event;
    logic [1:0]    winner_source_id;
    logic          req, busy, overflow, grant_err, timeout;
    logic [PW-1:0] pending_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_req, m_gap, m_ovf, m_gerr, m_to;
    int m_pend, m_age;

    typedef struct packed {
        logic [5:0] in;   // rst, push, ready, event, winner[1:0]
        logic [7:0] exp;  // req, pending_cnt[3:0], busy, overflow, grant_err
    } vec_t;

    vec_t tbl [26];

    always #5 clk = ~clk;

    ack_bus_requester #(
        .SOURCE_ID (SRC),
        .PEND_W    (PW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ack_push         (ack_push),
        .req              (req),
        .ack_ready        (ack_ready),
        .winner_source_id (winner_source_id),
        .ack_event        (ack_event),
        .pending_cnt      (pending_cnt),
        .busy             (busy),
        .overflow         (overflow),
        .grant_err        (grant_err),
        .timeout          (timeout)
    );

    function automatic logic [8:0] obs();
        return {req, pending_cnt, busy, overflow, grant_err, timeout};
    endfunction

    function automatic logic [8:0] model_obs();
        logic m_busy;
        m_busy = m_req || m_gap || (m_pend > 0);
        return {m_req, 4'(m_pend), m_busy, m_ovf, m_gerr, m_to};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue-of-acks view: requesting while acks wait, one quiet cycle after each hand-off.
    task automatic model_step(input logic r, input logic p, input logic rd, input logic ev,
                              input logic [1:0] w);
        bit grant, expire, taken;
        if (r) begin
            m_req = 0; m_gap = 0; m_pend = 0; m_age = 0;
            m_ovf = 0; m_gerr = 0; m_to = 0;
            return;
        end
        grant  = m_req && rd && ev && (w == SRC);
        expire = TO_EN && m_req && !grant && (m_age + 1 == 255);
        taken  = grant || expire;
        if (rd && !grant) m_gerr = 1;
        if (expire) m_to = 1;
        if (p && !taken) begin
            if (m_pend == CMAX) m_ovf = 1;
            else m_pend++;
        end else if (taken && !p) begin
            m_pend--;
        end
        if (m_req && !taken) begin
            m_age++;
        end else if (m_req) begin
            m_req = 0;
            m_gap = 1;
        end else begin
            m_gap = 0;
            m_req = (m_pend > 0);
            m_age = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic p, input logic rd, input logic ev,
                         input logic [1:0] w);
        rst = r; ack_push = p; ack_ready = rd; ack_event = ev; winner_source_id = w;
        @(posedge clk);
        model_step(r, p, rd, ev, w);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic push_cycle();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic reset_cycle();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        logic [5:0]  pat;
        logic [11:0] req_cnts;
        logic        rd, ev, p, r;
        logic [1:0]  w;

        tbl = '{
            '{6'b1_0_0_0_00, 8'b0_0000_0_0_0},
            '{6'b0_0_0_0_00, 8'b0_0000_0_0_0},
            '{6'b0_1_0_0_00, 8'b1_0001_1_0_0},
            '{6'b0_0_0_0_00, 8'b1_0001_1_0_0},
            '{6'b0_0_0_0_00, 8'b1_0001_1_0_0},
            '{6'b0_0_1_1_01, 8'b0_0000_1_0_0},
            '{6'b0_0_0_0_00, 8'b0_0000_0_0_0},
            '{6'b0_1_0_0_00, 8'b1_0001_1_0_0},
            '{6'b0_0_1_1_10, 8'b1_0001_1_0_1},
            '{6'b0_0_1_0_01, 8'b1_0001_1_0_1},
            '{6'b0_0_1_1_01, 8'b0_0000_1_0_1},
            '{6'b0_0_0_0_00, 8'b0_0000_0_0_1},
            '{6'b1_0_0_0_00, 8'b0_0000_0_0_0},
            '{6'b0_0_1_1_01, 8'b0_0000_0_0_1},
            '{6'b1_1_1_1_01, 8'b0_0000_0_0_0},
            '{6'b0_1_0_0_00, 8'b1_0001_1_0_0},
            '{6'b0_1_0_0_00, 8'b1_0010_1_0_0},
            '{6'b0_1_1_1_01, 8'b0_0010_1_0_0},
            '{6'b0_0_0_0_00, 8'b1_0010_1_0_0},
            '{6'b0_0_1_1_01, 8'b0_0001_1_0_0},
            '{6'b0_0_0_0_00, 8'b1_0001_1_0_0},
            '{6'b0_0_1_1_01, 8'b0_0000_1_0_0},
            '{6'b0_0_0_0_00, 8'b0_0000_0_0_0},
            '{6'b0_1_0_0_00, 8'b1_0001_1_0_0},
            '{6'b1_1_0_0_00, 8'b0_0000_0_0_0},
            '{6'b0_0_0_0_00, 8'b0_0000_0_0_0}
        };

        rst = 1'b1; ack_push = 1'b0; ack_ready = 1'b0; ack_event = 1'b0;
        winner_source_id = 2'b00;

        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1:0]);
            check($sformatf("vec%0d", i), 16'(obs()), 16'({tbl[i].exp, 1'b0}));
        end

        // Three queued acks drained by granting every REQ cycle.
        reset_cycle();
        push_cycle(); push_cycle(); push_cycle();
        check("burst3_cnt", 16'(pending_cnt), 16'd3);
        pat      = 6'(req);
        req_cnts = 12'(pending_cnt);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, req, req, SRC);
            pat = {pat[4:0], req};
            if (req) req_cnts = {req_cnts[7:0], 4'(pending_cnt)};
        end
        check("burst3_req_pattern", 16'(pat), 16'(6'b101010));
        check("burst3_cnt_per_req", 16'(req_cnts), 16'h321);
        idle_cycle();
        check("burst3_final", 16'({pending_cnt, busy, req}), 16'd0);

        // Saturation: sixteen pushes with no grant.
        reset_cycle();
        for (int k = 0; k < 16; k++) push_cycle();
        check("sat_cnt", 16'(pending_cnt), 16'(CMAX));
        check("sat_overflow", 16'(overflow), 16'd1);
        idle_cycle();
        check("sat_req_held", 16'({req, pending_cnt}), 16'({1'b1, 4'(CMAX)}));

        // Single push left waiting with no grant.
        reset_cycle();
        push_cycle();
`ifdef ACK_REQ_TIMEOUT_EN
        for (int k = 0; k < 254; k++) idle_cycle();
        check("to_before", 16'({req, timeout, pending_cnt}), 16'({2'b10, 4'd1}));
        idle_cycle();
        check("to_after", 16'({req, timeout, pending_cnt}), 16'({2'b01, 4'd0}));
`else
        for (int k = 0; k < 300; k++) idle_cycle();
        check("no_to_held", 16'({req, timeout, pending_cnt}), 16'({2'b10, 4'd1}));
`endif

        // Randomized traffic against the reference model.
        reset_cycle();
        for (int k = 0; k < 3000; k++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            r   = ($urandom_range(0, 299) == 0);
            p   = ($urandom_range(0, 9) < 4);
            rd  = (m_req && sel < 6) || (sel == 9);
            ev  = rd ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            w   = (rd && $urandom_range(0, 7) != 0) ? SRC : 2'($urandom_range(0, 3));
            cycle(r, p, rd, ev, w);
            check($sformatf("rand%0d", k), 16'(obs()), 16'(model_obs()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
